mdu_scheduler: RTL and testbench
================================

Name: mdu_scheduler

Overview:
- Sequencing controller for the multi-cycle multiply/divide unit and the HI/LO register pair in the 5-stage MIPS pipeline.
- Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from the EX stage and runs a busy countdown per operation.
- Owns HI/LO and raises the MDU structural-hazard stall for the ID-stage instruction.
- Sits beside the ALU in EX; its stall output is ORed with the existing data-hazard stall.

Parameters:
- MULT_CYCLES, 5, busy duration of MULT/MULTU, range 1..15.
- DIV_CYCLES, 10, busy duration of DIV/DIVU, range 1..15.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  synchronous reset, active-low.
- start  in  1  valid MDU instruction in EX this cycle.
- op  in  4  0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7-10 MADD/MADDU/MSUB/MSUBU (optional feature only), others reserved.
- rs_val  in  32  forwarded rs operand.
- rt_val  in  32  forwarded rt operand.
- cancel  in  1  exception/interrupt flush of the EX instruction this cycle.
- id_uses_mdu  in  1  ID instruction is mult/div/mfhi/mflo/mthi/mtlo (or madd family).
- stall_md  out  1  stall request for IF/ID.
- busy  out  1  calculation in flight.
- hi  out  32  HI register.
- lo  out  32  LO register.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-low (reset_n sampled on rising clk).
- Reset: hi=0, lo=0, busy=0, state IDLE, counter=0, latched operands=0. Reset mid-operation aborts the operation and leaves no partial HI/LO write.
- FSM states: IDLE and BUSY.
- IDLE -> BUSY: when start & !cancel & op in {1..4}.
  - Latch rs_val, rt_val and op.
  - Load counter with MULT_CYCLES (op 1,2) or DIV_CYCLES (op 3,4).
- BUSY: counter decrements each cycle. At the edge where counter reaches 0, write hi/lo from the latched operands and return to IDLE.
- Timing: busy=1 in exactly N cycles, from the cycle after start through cycle start+N. New hi/lo are visible in cycle start+N+1, the same cycle busy falls.
- MTHI/MTLO: when start & !cancel in IDLE, hi (or lo) <= rs_val at the next edge. No busy.
- cancel: qualifies only the start cycle and suppresses every state change. An op already in flight always completes, because the instruction has already committed past EX.
- start while BUSY: illegal, since stall_md prevents it. The block ignores it and the bench asserts it never occurs.
- stall_md = id_uses_mdu & (busy | (start & !cancel & op in {1..4})). It is combinational, so mfhi in ID stalls in the same cycle mult is in EX.
- Multiply:
  - MULT gives signed 64-bit {hi,lo} = rs*rt.
  - MULTU gives the unsigned product.
- Divide:
  - DIV: lo=quotient, hi=remainder, truncating toward zero, remainder takes the dividend's sign.
  - DIVU: the unsigned equivalent.
- Divide by zero: lo=32'hFFFFFFFF, hi=dividend (both DIV and DIVU).
- DIV overflow: 32'h80000000 / 32'hFFFFFFFF gives lo=32'h80000000, hi=0.
- Reserved op: no effect when start=1.

Optional Feature:
- Macro: MDU_MADD_EN.
- With the macro defined, ops 7-10 are MADD, MADDU, MSUB and MSUBU.
  - {hi,lo} +/- (rs*rt), signed for MADD/MSUB and unsigned for MADDU/MSUBU.
  - Arithmetic is 64-bit modulo.
  - Busy for MULT_CYCLES.
  - The accumulator base is the {hi,lo} value at the commit edge.
- Without the macro, ops 7-10 are reserved with no effect, and no accumulate logic is synthesized.

Decomposition:
- Shared package mdu_pkg holds:
  - the op encoding constants,
  - the state encoding (IDLE/BUSY),
  - the default cycle counts,
  - the divide-by-zero/overflow result constants.
- One sub-module, mdu_arith: purely combinational 64-bit result from latched op/operands (plus {hi,lo} when MDU_MADD_EN). mdu_scheduler keeps the FSM, counter, stall and HI/LO registers.

Test Plan:
- MULT rs=-3, rt=7 at cycle 0 -> busy cycles 1-5, {hi,lo}=64'hFFFFFFFF_FFFFFFEB visible cycle 6, stall_md=1 cycles 0-5 with id_uses_mdu=1.
- DIVU rs=100, rt=7 -> busy 10 cycles, lo=14, hi=2; DIV rs=-7, rt=2 -> lo=-3, hi=-1.
- DIV rs=5, rt=0 -> lo=32'hFFFFFFFF, hi=5; DIV 32'h80000000/-1 -> lo=32'h80000000, hi=0.
- start+cancel with MULT -> busy stays 0, stall_md=0, hi/lo unchanged; MTHI rs=32'hDEADBEEF without cancel -> hi=DEADBEEF next cycle, busy 0.
- reset_n low in cycle 3 of DIV -> next cycle busy=0, hi=lo=0, no later write.
- MDU_MADD_EN: hi=0, lo=32'hFFFFFFFF, MADDU 1*1 -> {hi,lo}=64'h1_00000000; macro off, op 7 -> no effect.

Source files
------------

// File: rtl/mdu_pkg.sv
// mdu_pkg: shared definitions for the multiply/divide scheduler.
//   - op encodings seen on the EX-stage op bus
//   - FSM state encoding (IDLE/BUSY)
//   - default busy durations for multiply and divide
//   - fixed results for divide-by-zero and signed-divide overflow
//   - op classification helpers
// Optional build macro: MDU_MADD_EN (adds MADD/MADDU/MSUB/MSUBU as ops 7-10).
package mdu_pkg;

  localparam logic [3:0] OP_NONE  = 4'd0;
  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
`ifdef MDU_MADD_EN
  localparam logic [3:0] OP_MADD  = 4'd7;
  localparam logic [3:0] OP_MADDU = 4'd8;
  localparam logic [3:0] OP_MSUB  = 4'd9;
  localparam logic [3:0] OP_MSUBU = 4'd10;
`endif

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

  // Divide by zero: quotient all ones, remainder is the dividend.
  localparam logic [31:0] DIV0_LO = 32'hFFFF_FFFF;
  // Most-negative / -1 wraps: quotient stays most-negative, remainder zero.
  localparam logic [31:0] OVF_DIVIDEND = 32'h8000_0000;
  localparam logic [31:0] OVF_DIVISOR  = 32'hFFFF_FFFF;
  localparam logic [31:0] OVF_LO       = 32'h8000_0000;
  localparam logic [31:0] OVF_HI       = 32'h0000_0000;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  // True for ops that occupy the unit for a multi-cycle calculation.
  function automatic logic is_calc_op(input logic [3:0] op);
    logic r;
    r = (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
`ifdef MDU_MADD_EN
    r = r || (op == OP_MADD) || (op == OP_MADDU) || (op == OP_MSUB) || (op == OP_MSUBU);
`endif
    return r;
  endfunction

  // True for ops that take the divide duration.
  function automatic logic is_div_op(input logic [3:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/mdu_arith.sv
// mdu_arith: purely combinational 64-bit {hi,lo} result for a latched MDU op.
// Ports:
//   i_op     latched op code
//   i_rs     latched rs operand (multiplicand / dividend)
//   i_rt     latched rt operand (multiplier / divisor)
//   i_acc    current {hi,lo}, accumulator base (only with MDU_MADD_EN)
//   o_result {hi,lo} value to commit
// Optional build macro: MDU_MADD_EN.
module mdu_arith
  import mdu_pkg::*;
(
  input  logic [3:0]  i_op,
  input  logic [31:0] i_rs,
  input  logic [31:0] i_rt,
`ifdef MDU_MADD_EN
  input  logic [63:0] i_acc,
`endif
  output logic [63:0] o_result
);

  logic [63:0] w_prod_s;
  logic [63:0] w_prod_u;
  logic [31:0] w_a_mag;
  logic [31:0] w_b_mag;
  logic [31:0] w_q_mag;
  logic [31:0] w_r_mag;
  logic [31:0] w_q_s;
  logic [31:0] w_r_s;
  logic [31:0] w_q_u;
  logic [31:0] w_r_u;

  assign w_prod_s = $signed(i_rs) * $signed(i_rt);
  assign w_prod_u = {32'h0000_0000, i_rs} * {32'h0000_0000, i_rt};

  // Signed divide is done on magnitudes so the most-negative dividend never
  // reaches a native signed divide; signs are restored afterwards (quotient
  // negative when signs differ, remainder follows the dividend).
  assign w_a_mag = i_rs[31] ? (32'h0000_0000 - i_rs) : i_rs;
  assign w_b_mag = i_rt[31] ? (32'h0000_0000 - i_rt) : i_rt;
  assign w_q_mag = w_a_mag / w_b_mag;
  assign w_r_mag = w_a_mag % w_b_mag;
  assign w_q_s   = (i_rs[31] ^ i_rt[31]) ? (32'h0000_0000 - w_q_mag) : w_q_mag;
  assign w_r_s   = i_rs[31] ? (32'h0000_0000 - w_r_mag) : w_r_mag;
  assign w_q_u   = i_rs / i_rt;
  assign w_r_u   = i_rs % i_rt;

  // Result select per op; zero divisor and overflow override the quotient.
  always_comb begin
    o_result = 64'h0;
    case (i_op)
      OP_NONE:  o_result = 64'h0;
      OP_MULT:  o_result = w_prod_s;
      OP_MULTU: o_result = w_prod_u;
      OP_DIV: begin
        if (i_rt == 32'h0000_0000) begin
          o_result = {i_rs, DIV0_LO};
        end else if ((i_rs == OVF_DIVIDEND) && (i_rt == OVF_DIVISOR)) begin
          o_result = {OVF_HI, OVF_LO};
        end else begin
          o_result = {w_r_s, w_q_s};
        end
      end
      OP_DIVU: begin
        if (i_rt == 32'h0000_0000) begin
          o_result = {i_rs, DIV0_LO};
        end else begin
          o_result = {w_r_u, w_q_u};
        end
      end
`ifdef MDU_MADD_EN
      OP_MADD:  o_result = i_acc + w_prod_s;
      OP_MADDU: o_result = i_acc + w_prod_u;
      OP_MSUB:  o_result = i_acc - w_prod_s;
      OP_MSUBU: o_result = i_acc - w_prod_u;
`endif
      default:  o_result = 64'h0;
    endcase
  end

endmodule

// File: rtl/mdu_scheduler.sv
// mdu_scheduler: sequencing controller for the multi-cycle MDU and HI/LO.
// Ports:
//   clk          rising-edge clock
//   reset_n      synchronous active-low reset
//   start        valid MDU instruction in EX
//   op           MDU op code (see mdu_pkg)
//   rs_val       forwarded rs operand
//   rt_val       forwarded rt operand
//   cancel       flush of the EX instruction this cycle
//   id_uses_mdu  ID instruction touches the MDU or HI/LO
//   stall_md     combinational stall request for IF/ID
//   busy         calculation in flight
//   hi, lo       HI/LO registers
// Optional build macro: MDU_MADD_EN (accumulate ops 7-10).
module mdu_scheduler
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [3:0]  op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        cancel,
  input  logic        id_uses_mdu,
  output logic        stall_md,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  state_e      r_state;
  state_e      w_state_nxt;
  logic [3:0]  r_cnt;
  logic [3:0]  w_cnt_nxt;
  logic        w_latch;
  logic        w_commit;
  logic        r_busy;
  logic [3:0]  r_op;
  logic [31:0] r_rs;
  logic [31:0] r_rt;
  logic [31:0] r_hi;
  logic [31:0] r_lo;
  logic        w_start_calc;
  logic        w_start_mthi;
  logic        w_start_mtlo;
  logic [63:0] w_result;

  assign w_start_calc = start & ~cancel & is_calc_op(op);
  assign w_start_mthi = start & ~cancel & (op == OP_MTHI);
  assign w_start_mtlo = start & ~cancel & (op == OP_MTLO);

  // Stall is combinational so a HI/LO reader in ID holds in the same cycle
  // the calculation is launched from EX.
  assign stall_md = id_uses_mdu & (r_busy | w_start_calc);
  assign busy     = r_busy;
  assign hi       = r_hi;
  assign lo       = r_lo;

  mdu_arith u_arith (
    .i_op     (r_op),
    .i_rs     (r_rs),
    .i_rt     (r_rt),
`ifdef MDU_MADD_EN
    .i_acc    ({r_hi, r_lo}),
`endif
    .o_result (w_result)
  );

  // Next-state, counter and commit decode.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_latch     = 1'b0;
    w_commit    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_start_calc) begin
          w_state_nxt = ST_BUSY;
          w_latch     = 1'b1;
          w_cnt_nxt   = is_div_op(op) ? 4'(DIV_CYCLES) : 4'(MULT_CYCLES);
        end else begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = 4'd0;
        end
      end
      ST_BUSY: begin
        // Count value 1 means this edge is the one where the count hits zero.
        if (r_cnt <= 4'd1) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = 4'd0;
          w_commit    = 1'b1;
        end else begin
          w_state_nxt = ST_BUSY;
          w_cnt_nxt   = r_cnt - 4'd1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = 4'd0;
      end
    endcase
  end

  // State, counter and busy flag registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= 4'd0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_busy  <= (w_state_nxt == ST_BUSY);
    end
  end

  // Operand and op latch, captured only at launch.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_op <= 4'd0;
      r_rs <= 32'h0000_0000;
      r_rt <= 32'h0000_0000;
    end else if (w_latch) begin
      r_op <= op;
      r_rs <= rs_val;
      r_rt <= rt_val;
    end else begin
      r_op <= r_op;
      r_rs <= r_rs;
      r_rt <= r_rt;
    end
  end

  // HI/LO: written by a finished calculation or by MTHI/MTLO while idle.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_hi <= 32'h0000_0000;
      r_lo <= 32'h0000_0000;
    end else if (w_commit) begin
      r_hi <= w_result[63:32];
      r_lo <= w_result[31:0];
    end else if (r_state == ST_IDLE) begin
      r_hi <= w_start_mthi ? rs_val : r_hi;
      r_lo <= w_start_mtlo ? rs_val : r_lo;
    end else begin
      r_hi <= r_hi;
      r_lo <= r_lo;
    end
  end

endmodule

// File: tb/tb_mdu_scheduler.sv
// Self-checking bench for mdu_scheduler: table of calculation vectors run
// through a scoreboard queue, plus hand sequences for cancel, MTHI/MTLO,
// reserved ops, optional accumulate, and reset during a divide.
module tb_mdu_scheduler;
  import mdu_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [3:0]  op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        cancel;
  logic        id_uses_mdu;
  logic        stall_md;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_tests = 0;
  int n_fail  = 0;
  logic proto_err = 1'b0;
  logic [31:0] m_hi;
  logic [31:0] m_lo;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [63:0] exp;
    int          cyc;
  } vec_t;

  localparam int NV = 10;
  vec_t vecs[NV];
  vec_t sb[$];

  mdu_scheduler #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .op(op),
    .rs_val(rs_val), .rt_val(rt_val), .cancel(cancel),
    .id_uses_mdu(id_uses_mdu), .stall_md(stall_md), .busy(busy),
    .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  // Protocol watch: the pipeline must never present start while busy.
  always @(negedge clk) begin
    if (reset_n === 1'b1 && busy === 1'b1 && start === 1'b1) proto_err <= 1'b1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  // Present one EX-stage instruction for a single cycle; checks the
  // combinational stall while it is on the bus.
  task automatic issue(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic c, input logic idu, input logic exp_stall);
    @(negedge clk);
    start = 1'b1; op = o; rs_val = a; rt_val = b; cancel = c; id_uses_mdu = idu;
    #1;
    chk("stall_issue", {63'h0, stall_md}, {63'h0, exp_stall});
    @(posedge clk);
    #1;
    start = 1'b0; cancel = 1'b0; op = 4'd0;
  endtask

  // Count busy cycles (bounded) and check the stall tracks busy meanwhile.
  task automatic wait_idle(input logic exp_stall, output int n);
    n = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (busy !== 1'b1) break;
      n++;
      chk("stall_while_busy", {63'h0, stall_md}, {63'h0, exp_stall});
    end
  endtask

  task automatic run_calc(input vec_t v, input logic idu);
    int n;
    vec_t e;
    issue(v.op, v.rs, v.rt, 1'b0, idu, idu);
    sb.push_back(v);
    wait_idle(idu, n);
    e = sb.pop_front();
    chk("busy_cycles", 64'(n), 64'(e.cyc));
    chk("hi", {32'h0, hi}, {32'h0, e.exp[63:32]});
    chk("lo", {32'h0, lo}, {32'h0, e.exp[31:0]});
    m_hi = e.exp[63:32];
    m_lo = e.exp[31:0];
  endtask

  task automatic check_no_effect(input string name);
    @(negedge clk);
    chk({name, "_busy"}, {63'h0, busy}, 64'h0);
    chk({name, "_hi"}, {32'h0, hi}, {32'h0, m_hi});
    chk({name, "_lo"}, {32'h0, lo}, {32'h0, m_lo});
  endtask

  initial begin
    vecs[0] = '{OP_MULT,  32'hFFFF_FFFD, 32'd7,        64'hFFFF_FFFF_FFFF_FFEB, 5};
    vecs[1] = '{OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 5};
    vecs[2] = '{OP_DIVU,  32'd100,       32'd7,        {32'd2, 32'd14},         10};
    vecs[3] = '{OP_DIV,   32'hFFFF_FFF9, 32'd2,        {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 10};
    vecs[4] = '{OP_DIV,   32'd5,         32'd0,        {32'd5, 32'hFFFF_FFFF},  10};
    vecs[5] = '{OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, {32'h0, 32'h8000_0000}, 10};
    vecs[6] = '{OP_DIVU,  32'd7,         32'd0,        {32'd7, 32'hFFFF_FFFF},  10};
    vecs[7] = '{OP_MULT,  32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 5};
    vecs[8] = '{OP_DIVU,  32'hFFFF_FFFF, 32'd2,        {32'd1, 32'h7FFF_FFFF},  10};
    vecs[9] = '{OP_DIV,   32'd7,         32'hFFFF_FFFE, {32'd1, 32'hFFFF_FFFD}, 10};

    reset_n = 1'b0; start = 1'b0; op = 4'd0; rs_val = 32'h0; rt_val = 32'h0;
    cancel = 1'b0; id_uses_mdu = 1'b1;
    m_hi = 32'h0; m_lo = 32'h0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;

    // Reset state.
    @(negedge clk);
    chk("rst_busy", {63'h0, busy}, 64'h0);
    chk("rst_hi", {32'h0, hi}, 64'h0);
    chk("rst_lo", {32'h0, lo}, 64'h0);
    chk("rst_stall", {63'h0, stall_md}, 64'h0);

    // Calculation vectors through the scoreboard.
    for (int i = 0; i < NV; i++) run_calc(vecs[i], 1'b1);

    // Multiply with no MDU user in ID: no stall at any point.
    begin
      vec_t v;
      v = '{OP_MULT, 32'd2, 32'd3, 64'd6, 5};
      run_calc(v, 1'b0);
    end

    // Cancelled multiply: nothing changes.
    issue(OP_MULT, 32'd3, 32'd4, 1'b1, 1'b1, 1'b0);
    check_no_effect("cancel");

    // Cancelled MTHI: nothing changes.
    issue(OP_MTHI, 32'h1111_1111, 32'd0, 1'b1, 1'b1, 1'b0);
    check_no_effect("cancel_mthi");

    // MTHI / MTLO.
    issue(OP_MTHI, 32'hDEAD_BEEF, 32'd0, 1'b0, 1'b1, 1'b0);
    m_hi = 32'hDEAD_BEEF;
    check_no_effect("mthi");
    issue(OP_MTLO, 32'h1234_5678, 32'd0, 1'b0, 1'b1, 1'b0);
    m_lo = 32'h1234_5678;
    check_no_effect("mtlo");

    // Reserved op.
    issue(4'hF, 32'd9, 32'd9, 1'b0, 1'b1, 1'b0);
    check_no_effect("reserved");

`ifdef MDU_MADD_EN
    issue(OP_MTHI, 32'h0, 32'd0, 1'b0, 1'b1, 1'b0);
    issue(OP_MTLO, 32'hFFFF_FFFF, 32'd0, 1'b0, 1'b1, 1'b0);
    begin
      vec_t v;
      v = '{OP_MADDU, 32'd1, 32'd1, 64'h0000_0001_0000_0000, 5};
      run_calc(v, 1'b1);
    end
`else
    issue(4'd7, 32'd1, 32'd1, 1'b0, 1'b1, 1'b0);
    check_no_effect("op7_off");
`endif

    // Reset in cycle 3 of a divide: aborts with no later write.
    issue(OP_DIVU, 32'd100, 32'd7, 1'b0, 1'b1, 1'b1);
    @(negedge clk);
    @(negedge clk);
    @(posedge clk);
    #1 reset_n = 1'b0;
    @(posedge clk);
    #1 reset_n = 1'b1;
    m_hi = 32'h0;
    m_lo = 32'h0;
    check_no_effect("rst_mid");
    repeat (15) @(negedge clk);
    check_no_effect("rst_late");

    chk("no_start_while_busy", {63'h0, proto_err}, 64'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
